spi_cmd_decoder: RTL and testbench

Byte-level command decoder that sits directly downstream of the SPI slave shift stage. It consumes each received MOSI byte (`rx_data` + `rx_valid` strobe) together with the chip-select level, and parses frames into register writes and reads against a small register bank. It returns read data to the shift stage for MISO and drives the board `led` from register 0.

---
 rtl/spi_cmd_decoder.sv | 174 +++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// Byte-level SPI command decoder: parses write/read frames against a 2^ADDR_W x 8 register bank.
// Build option: define SPI_CMD_TIMEOUT_EN to abort a frame that stalls for TIMEOUT cycles.
module spi_cmd_decoder #(
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clock_in,
    input  logic                      rs_n,
    input  logic                      cs,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_load,
    output logic [8*(2**ADDR_W)-1:0]  reg_out,
    output logic                      led,
    output logic                      err,
    output logic [2:0]                dbg_state
);

    localparam int N = 2 ** ADDR_W;
    // Command bits [6:ADDR_W] are reserved and must be zero.
    localparam logic [7:0] RSV_MASK = 8'h7F & ~8'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("spi_cmd_decoder: TIMEOUT must be in 1..65535");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          regs_q [N];
    logic [7:0]          regs_d [N];
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_load_q, tx_load_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_bad;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0]         cnt_q, cnt_d;
`endif

    assign cmd_addr = rx_data[ADDR_W-1:0];
    assign cmd_bad  = (rx_data & RSV_MASK) != 8'h00;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        regs_d    = regs_q;
        tx_data_d = tx_data_q;
        tx_load_d = 1'b0;
        err_d     = err_q;
`ifdef SPI_CMD_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        // Chip select deasserted dominates everything, including a coincident byte.
        if (cs) begin
            state_d = S_IDLE;
            addr_d  = '0;
`ifdef SPI_CMD_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    err_d   = 1'b0;
                    addr_d  = '0;
`ifdef SPI_CMD_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
                S_CMD: begin
                    if (rx_valid) begin
                        if (cmd_bad) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else if (rx_data[7]) begin
                            addr_d  = cmd_addr;
                            state_d = S_WR;
                        end else begin
                            tx_data_d = regs_q[cmd_addr];
                            tx_load_d = 1'b1;
                            addr_d    = cmd_addr + ADDR_W'(1);
                            state_d   = S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (rx_valid) begin
                        regs_d[addr_q] = rx_data;
                        addr_d         = addr_q + ADDR_W'(1);
                    end
                end
                S_RD: begin
                    if (rx_valid) begin
                        tx_data_d = regs_q[addr_q];
                        tx_load_d = 1'b1;
                        addr_d    = addr_q + ADDR_W'(1);
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

`ifdef SPI_CMD_TIMEOUT_EN
            // Idle-cycle watchdog, only while a frame is actively being parsed.
            if (state_q == S_CMD || state_q == S_WR || state_q == S_RD) begin
                if (rx_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clock_in or negedge rs_n) begin
        if (!rs_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            tx_data_q <= 8'h00;
            tx_load_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= 8'h00;
            end
`ifdef SPI_CMD_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            err_q     <= err_d;
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= regs_d[i];
            end
`ifdef SPI_CMD_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_reg_out
        assign reg_out[8*k +: 8] = regs_q[k];
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign led       = regs_q[0][0];
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder (ADDR_W = 2, TIMEOUT = 10).
module tb_spi_cmd_decoder;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    logic        clock_in;
    logic        rs_n;
    logic        cs;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic [31:0] reg_out;
    logic        led;
    logic        err;
    logic [2:0]  dbg_state;

    int passed = 0;
    int total  = 0;

    spi_cmd_decoder #(.ADDR_W(2), .TIMEOUT(10)) dut (
        .clock_in (clock_in),
        .rs_n     (rs_n),
        .cs       (cs),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .reg_out  (reg_out),
        .led      (led),
        .err      (err),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Driver tasks: inputs change 1ns after the rising edge, outputs are checked there too.
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        cs = 1'b0;
        tick();
    endtask

    task automatic end_frame();
        cs = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rs_n = 1'b0;
        cs = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        #12;
        total++;
        if (reg_out !== 32'h0 || tx_data !== 8'h00 || tx_load !== 1'b0 || err !== 1'b0 || led !== 1'b0)
            $display("FAIL reset_outputs: reg_out=%h tx_data=%h tx_load=%b err=%b led=%b, expected all zero",
                     reg_out, tx_data, tx_load, err, led);
        else passed++;
        rs_n = 1'b1;
        tick();
        tick();
        total++;
        if (tx_load !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL reset_release: tx_load=%b state=%0d, expected 0 and %0d", tx_load, dbg_state, ST_IDLE);
        else passed++;
    endtask

    task automatic test_write_burst();
        start_frame();
        send_byte(8'h81);
        send_byte(8'hA5);
        total++;
        if (reg_out !== 32'h0000A500)
            $display("FAIL wr_first: reg_out=%h expected 0000a500", reg_out);
        else passed++;
        send_byte(8'h3C);
        total++;
        if (reg_out !== 32'h003CA500 || led !== 1'b0)
            $display("FAIL wr_second: reg_out=%h led=%b expected 003ca500 led=0", reg_out, led);
        else passed++;
        end_frame();
        start_frame();
        send_byte(8'h80);
        total++;
        if (led !== 1'b0)
            $display("FAIL led_before: led=%b expected 0", led);
        else passed++;
        send_byte(8'h01);
        total++;
        if (led !== 1'b1 || reg_out !== 32'h003CA501)
            $display("FAIL led_set: led=%b reg_out=%h expected 1 and 003ca501", led, reg_out);
        else passed++;
        end_frame();
    endtask

    task automatic test_read_wrap();
        start_frame();
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        end_frame();
        total++;
        if (reg_out !== 32'h44332211)
            $display("FAIL rd_setup: reg_out=%h expected 44332211", reg_out);
        else passed++;
        start_frame();
        send_byte(8'h03);
        total++;
        if (tx_load !== 1'b1 || tx_data !== 8'h44 || dbg_state !== ST_RD)
            $display("FAIL rd_cmd: tx_load=%b tx_data=%h state=%0d expected 1, 44, %0d",
                     tx_load, tx_data, dbg_state, ST_RD);
        else passed++;
        tick();
        total++;
        if (tx_load !== 1'b0 || tx_data !== 8'h44)
            $display("FAIL rd_pulse_width: tx_load=%b tx_data=%h expected 0 and 44 held", tx_load, tx_data);
        else passed++;
        send_byte(8'hEE);
        total++;
        if (tx_load !== 1'b1 || tx_data !== 8'h11)
            $display("FAIL rd_wrap: tx_load=%b tx_data=%h expected 1 and 11", tx_load, tx_data);
        else passed++;
        send_byte(8'hEE);
        total++;
        if (tx_load !== 1'b1 || tx_data !== 8'h22)
            $display("FAIL rd_back_to_back: tx_load=%b tx_data=%h expected 1 and 22", tx_load, tx_data);
        else passed++;
        tick();
        total++;
        if (tx_load !== 1'b0 || tx_data !== 8'h22)
            $display("FAIL rd_hold: tx_load=%b tx_data=%h expected 0 and 22", tx_load, tx_data);
        else passed++;
        end_frame();
    endtask

    task automatic test_bad_cmd();
        start_frame();
        send_byte(8'h44);
        total++;
        if (err !== 1'b1 || dbg_state !== ST_ERR)
            $display("FAIL bad_cmd_err: err=%b state=%0d expected 1 and %0d", err, dbg_state, ST_ERR);
        else passed++;
        send_byte(8'h77);
        send_byte(8'h99);
        total++;
        if (reg_out !== 32'h44332211 || err !== 1'b1 || tx_load !== 1'b0)
            $display("FAIL bad_cmd_ignore: reg_out=%h err=%b tx_load=%b expected 44332211, 1, 0",
                     reg_out, err, tx_load);
        else passed++;
        end_frame();
        total++;
        if (err !== 1'b1)
            $display("FAIL err_hold_idle: err=%b expected 1", err);
        else passed++;
        start_frame();
        total++;
        if (err !== 1'b0)
            $display("FAIL err_clear: err=%b expected 0", err);
        else passed++;
        end_frame();
    endtask

    task automatic test_abort();
        start_frame();
        send_byte(8'h80);
        cs       = 1'b1;
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        total++;
        if (reg_out[7:0] !== 8'h11 || dbg_state !== ST_IDLE)
            $display("FAIL abort_drop: reg0=%h state=%0d expected 11 and %0d", reg_out[7:0], dbg_state, ST_IDLE);
        else passed++;
        start_frame();
        send_byte(8'h80);
        send_byte(8'h07);
        total++;
        if (reg_out !== 32'h44332207 || led !== 1'b1)
            $display("FAIL abort_next: reg_out=%h led=%b expected 44332207 and 1", reg_out, led);
        else passed++;
        end_frame();
    endtask

    task automatic test_timeout();
        start_frame();
        send_byte(8'h80);
`ifdef SPI_CMD_TIMEOUT_EN
        repeat (9) tick();
        total++;
        if (err !== 1'b0)
            $display("FAIL timeout_early: err=%b after 9 idle cycles expected 0", err);
        else passed++;
        tick();
        total++;
        if (err !== 1'b1 || dbg_state !== ST_ERR)
            $display("FAIL timeout_fire: err=%b state=%0d expected 1 and %0d", err, dbg_state, ST_ERR);
        else passed++;
        send_byte(8'h55);
        total++;
        if (reg_out[7:0] !== 8'h07)
            $display("FAIL timeout_ignore: reg0=%h expected 07", reg_out[7:0]);
        else passed++;
`else
        repeat (20) tick();
        total++;
        if (err !== 1'b0 || dbg_state !== ST_WR)
            $display("FAIL no_timeout: err=%b state=%0d expected 0 and %0d", err, dbg_state, ST_WR);
        else passed++;
        send_byte(8'h55);
        total++;
        if (reg_out[7:0] !== 8'h55)
            $display("FAIL late_write: reg0=%h expected 55", reg_out[7:0]);
        else passed++;
`endif
        end_frame();
    endtask

    task automatic test_reset_midframe();
        start_frame();
        send_byte(8'h01);
        total++;
        if (tx_load !== 1'b1 || tx_data !== 8'h22)
            $display("FAIL midframe_read: tx_load=%b tx_data=%h expected 1 and 22", tx_load, tx_data);
        else passed++;
        #2;
        rs_n = 1'b0;
        #1;
        total++;
        if (reg_out !== 32'h0 || tx_data !== 8'h00 || tx_load !== 1'b0 || led !== 1'b0 ||
            err !== 1'b0 || dbg_state !== ST_IDLE)
            $display("FAIL async_reset: reg_out=%h tx_data=%h tx_load=%b led=%b err=%b state=%0d expected all zero",
                     reg_out, tx_data, tx_load, led, err, dbg_state);
        else passed++;
        cs = 1'b1;
        tick();
        rs_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (tx_load !== 1'b0 || dbg_state !== ST_IDLE)
                $display("FAIL post_reset_idle: cycle %0d tx_load=%b state=%0d expected 0 and %0d",
                         i, tx_load, dbg_state, ST_IDLE);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_bad_cmd();
        test_abort();
        test_timeout();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
